// File: rtl/fp_pkg.sv
// Shared binary32 constants, field layout and operand classification helpers
// for the floating-point datapath.
package fp_pkg;

    localparam int unsigned F32_BIAS    = 127;
    localparam logic [7:0]  F32_EXP_MAX = 8'hFF;
    localparam logic [31:0] F32_QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } f32_t;

    typedef enum logic [1:0] {
        SpNone,
        SpNan,
        SpInf,
        SpZero
    } special_e;

    function automatic logic is_nan(input f32_t x);
        return (x.exp == F32_EXP_MAX) && (x.frac != '0);
    endfunction

    function automatic logic is_inf(input f32_t x);
        return (x.exp == F32_EXP_MAX) && (x.frac == '0);
    endfunction

    function automatic logic is_zero(input f32_t x);
        return (x.exp == '0) && (x.frac == '0);
    endfunction

    function automatic logic is_sub(input f32_t x);
        return (x.exp == '0) && (x.frac != '0);
    endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) begin
                count = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/fp_div.sv
// Binary32 divider, round-to-nearest-even, fixed 28-cycle radix-2 restoring recurrence
// with a start/busy/done handshake.
module fp_div
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StRound
    } state_e;

    localparam logic [4:0]         LastIter = 5'd26;
    localparam logic signed [10:0] ExpBias  = 11'(F32_BIAS);

    state_e            state;
    logic [4:0]        iter_cnt;
    f32_t              op_n, op_d;
    logic              sign_q;
    logic signed [10:0] exp_q;
    logic [24:0]       rem_q;
    logic [23:0]       div_q;
    logic [25:0]       quo_q;
    special_e          spec_q;

    // Unpack: normalise subnormals and form the biased quotient exponent.
    logic [4:0]         lzc_n, lzc_d;
    logic [23:0]        man_n, man_d;
    logic signed [10:0] exp_n, exp_d, exp_un;
    logic [24:0]        rem_init;
    special_e           spec_un;

    fp_lzc24 u_lzc_n (
        .value ({1'b0, op_n.frac}),
        .count (lzc_n)
    );

    fp_lzc24 u_lzc_d (
        .value ({1'b0, op_d.frac}),
        .count (lzc_d)
    );

    always_comb begin
        man_n = is_sub(op_n) ? ({1'b0, op_n.frac} << lzc_n) : {1'b1, op_n.frac};
        man_d = is_sub(op_d) ? ({1'b0, op_d.frac} << lzc_d) : {1'b1, op_d.frac};
        exp_n = is_sub(op_n) ? 11'sd1 - $signed({6'd0, lzc_n}) : $signed({3'd0, op_n.exp});
        exp_d = is_sub(op_d) ? 11'sd1 - $signed({6'd0, lzc_d}) : $signed({3'd0, op_d.exp});
        exp_un = exp_n - exp_d + ExpBias;
        if (man_n < man_d) begin
            rem_init = {man_n, 1'b0};
            exp_un   = exp_un - 11'sd1;
        end else begin
            rem_init = {1'b0, man_n};
        end

        spec_un = SpNone;
        if (is_nan(op_n) || is_nan(op_d) || (is_zero(op_n) && is_zero(op_d)) ||
            (is_inf(op_n) && is_inf(op_d))) begin
            spec_un = SpNan;
        end else if (is_inf(op_n) || is_zero(op_d)) begin
            spec_un = SpInf;
        end else if (is_zero(op_n) || is_inf(op_d)) begin
            spec_un = SpZero;
        end
    end

    // One restoring step: the 25-bit shift discards the always-zero top bit.
    logic        rem_ge;
    logic [24:0] rem_sel, rem_next;
    logic [25:0] quo_next;

    always_comb begin
        rem_ge   = rem_q >= {1'b0, div_q};
        rem_sel  = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
        rem_next = rem_sel << 1;
        quo_next = {quo_q[24:0], rem_ge};
    end

    // Round and pack; tiny results are denormalised before rounding.
    logic signed [10:0] sh_s, exp_w;
    logic [4:0]         sh;
    logic [25:0]        mask, q_sh;
    logic               lost, sticky, guard, rnd, inc;
    logic [23:0]        sig;
    logic [24:0]        sig_r;
    logic [22:0]        frac_r;
    logic [31:0]        packed_res, result;

    always_comb begin
        sh_s  = 11'sd1 - exp_q;
        sh    = 5'd0;
        mask  = '0;
        lost  = 1'b0;
        q_sh  = quo_q;
        exp_w = exp_q;
        if (exp_q <= 11'sd0) begin
            sh    = (sh_s > 11'sd26) ? 5'd26 : sh_s[4:0];
            mask  = ~({26{1'b1}} << sh);
            lost  = |(quo_q & mask);
            q_sh  = quo_q >> sh;
            exp_w = 11'sd0;
        end

        sig    = q_sh[25:2];
        guard  = q_sh[1];
        rnd    = q_sh[0];
        sticky = (rem_q != '0) | lost;
        inc    = guard & (rnd | sticky | sig[0]);
        sig_r  = {1'b0, sig} + {24'd0, inc};

        frac_r = sig_r[22:0];
        if (sig_r[24]) begin
            frac_r = sig_r[23:1];
            exp_w  = exp_w + 11'sd1;
        end else if ((exp_w == 11'sd0) && sig_r[23]) begin
            exp_w = 11'sd1;
        end

        if (exp_w >= 11'sd255) begin
            packed_res = {sign_q, F32_EXP_MAX, 23'd0};
        end else begin
            packed_res = {sign_q, exp_w[7:0], frac_r};
        end

        case (spec_q)
            SpNan:   result = F32_QNAN;
            SpInf:   result = {sign_q, F32_EXP_MAX, 23'd0};
            SpZero:  result = {sign_q, 31'd0};
            default: result = packed_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            iter_cnt <= '0;
            op_n     <= '0;
            op_d     <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            spec_q   <= SpNone;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        op_n     <= dividend;
                        op_d     <= divisor;
                        iter_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= StIter;
                    end
                end
                StIter: begin
                    if (iter_cnt == '0) begin
                        sign_q <= op_n.sign ^ op_d.sign;
                        exp_q  <= exp_un;
                        rem_q  <= rem_init;
                        div_q  <= man_d;
                        quo_q  <= '0;
                        spec_q <= spec_un;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                    end
                    iter_cnt <= iter_cnt + 5'd1;
                    if (iter_cnt == LastIter) begin
                        state <= StRound;
                    end
                end
                StRound: begin
                    quotient <= result;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vectors, randomized operands against a
// wide-integer division model, handshake corner cases and mid-operation reset.
module tb_fp_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    fp_div dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Exact quotient as a wide integer, then rounded once to binary32.
    function automatic logic [31:0] ref_div(input logic [31:0] n, input logic [31:0] d);
        logic         s, nan_n, nan_d, inf_n, inf_d, zero_n, zero_d, sticky;
        logic [23:0]  mn, md;
        logic [127:0] num, q, kept, remb, half, mask;
        int           xn, xd, sc, p, lsb, sh;
        s      = n[31] ^ d[31];
        nan_n  = (n[30:23] == 8'hFF) && (n[22:0] != 0);
        nan_d  = (d[30:23] == 8'hFF) && (d[22:0] != 0);
        inf_n  = (n[30:23] == 8'hFF) && (n[22:0] == 0);
        inf_d  = (d[30:23] == 8'hFF) && (d[22:0] == 0);
        zero_n = (n[30:0] == 0);
        zero_d = (d[30:0] == 0);
        if (nan_n || nan_d || (zero_n && zero_d) || (inf_n && inf_d)) return 32'h7FC00000;
        if (inf_n || zero_d) return {s, 8'hFF, 23'd0};
        if (zero_n || inf_d) return {s, 31'd0};
        mn = (n[30:23] == 0) ? {1'b0, n[22:0]} : {1'b1, n[22:0]};
        md = (d[30:23] == 0) ? {1'b0, d[22:0]} : {1'b1, d[22:0]};
        xn = ((n[30:23] == 0) ? 1 : int'(n[30:23])) - 150;
        xd = ((d[30:23] == 0) ? 1 : int'(d[30:23])) - 150;
        num    = 128'(mn) << 60;
        q      = num / 128'(md);
        sticky = (num % 128'(md)) != 0;
        sc     = xn - xd - 60;
        p = 0;
        for (int i = 0; i < 128; i++) if (q[i]) p = i;
        lsb = p + sc - 23;
        if (lsb < -149) lsb = -149;
        sh = lsb - sc;
        if (sh > 120) sh = 120;
        kept = q >> sh;
        mask = (128'd1 << sh) - 128'd1;
        remb = q & mask;
        half = 128'd1 << (sh - 1);
        if ((remb > half) || ((remb == half) && (sticky || kept[0]))) kept = kept + 128'd1;
        if (kept == 0) return {s, 31'd0};
        if (kept[24]) begin
            kept = kept >> 1;
            lsb++;
        end
        if (!kept[23]) return {s, 8'd0, kept[22:0]};
        if (lsb + 150 >= 255) return {s, 8'hFF, 23'd0};
        return {s, 8'(lsb + 150), kept[22:0]};
    endfunction

    function automatic logic [31:0] gen_operand();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 11))
            0: x[30:0] = '0;
            1: x[30:0] = {8'hFF, 23'd0};
            2: begin x[30:23] = 8'hFF; x[0] = 1'b1; end
            3: x[30:23] = 8'h00;
            4: x[30:23] = 8'($urandom_range(250, 254));
            5: x[30:23] = 8'($urandom_range(1, 4));
            6: x[22:0] = '0;
            default: if (x[30:23] == 8'hFF) x[30:23] = 8'h80;
        endcase
        return x;
    endfunction

    // Drives one operation and reports the result and start-to-done latency (-1 on timeout).
    task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                          output logic [31:0] q, output int lat);
        int guard_cnt;
        guard_cnt = 0;
        while (busy && guard_cnt < 40) begin
            @(posedge clk); #1;
            guard_cnt++;
        end
        @(negedge clk);
        start = 1'b1;
        dividend = n;
        divisor = d;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        #1;
        checks += 3;
        if (quotient !== 32'h0) begin
            errors++; $display("FAIL reset_quotient: got %h expected 00000000", quotient);
        end
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] vn [8] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h00000000,
                                32'h7F7FFFFF, 32'h00800000, 32'h00000001, 32'h7F800000};
        logic [31:0] vd [8] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000,
                                32'h00800000, 32'h40000000, 32'h40000000, 32'h7F800000};
        logic [31:0] ve [8] = '{32'h3EAAAAAB, 32'hBF000000, 32'h7F800000, 32'h7FC00000,
                                32'h7F800000, 32'h00400000, 32'h00000000, 32'h7FC00000};
        logic [31:0] q;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(vn[i], vd[i], q, lat);
            checks += 2;
            if (lat !== 28) begin
                errors++; $display("FAIL directed_latency[%0d]: got %0d expected 28", i, lat);
            end
            if (q !== ve[i]) begin
                errors++;
                $display("FAIL directed_q[%0d] %h/%h: got %h expected %h", i, vn[i], vd[i], q, ve[i]);
            end
            if (i == 0) begin
                @(posedge clk); #1;
                checks += 2;
                if (done !== 1'b0) begin
                    errors++; $display("FAIL done_pulse_width: got done=%b expected 0", done);
                end
                if (quotient !== ve[0]) begin
                    errors++; $display("FAIL quotient_hold: got %h expected %h", quotient, ve[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] n, d, q, e;
        int lat;
        for (int i = 0; i < 300; i++) begin
            n = gen_operand();
            d = gen_operand();
            e = ref_div(n, d);
            run_op(n, d, q, lat);
            checks += 2;
            if (lat !== 28) begin
                errors++; $display("FAIL random_latency[%0d]: got %0d expected 28", i, lat);
            end
            if (q !== e) begin
                errors++; $display("FAIL random_q[%0d] %h/%h: got %h expected %h", i, n, d, q, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q;
        int lat;
        run_op(32'h40490FDB, 32'h402DF854, q, lat);
        // Now inside the done cycle: the next start must be accepted immediately.
        checks += 3;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done_cycle: got done=%b busy=%b expected 1 0", done, busy);
        end
        if (q !== ref_div(32'h40490FDB, 32'h402DF854)) begin
            errors++;
            $display("FAIL b2b_first_q: got %h expected %h", q, ref_div(32'h40490FDB, 32'h402DF854));
        end
        run_op(32'hC2F60000, 32'h3DCCCCCD, q, lat);
        if (lat !== 28) begin
            errors++; $display("FAIL b2b_latency: got %0d expected 28", lat);
        end
        checks++;
        if (q !== ref_div(32'hC2F60000, 32'h3DCCCCCD)) begin
            errors++;
            $display("FAIL b2b_second_q: got %h expected %h", q, ref_div(32'hC2F60000, 32'h3DCCCCCD));
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] e;
        int lat, extra;
        e = ref_div(32'h41200000, 32'h40E00000);
        @(negedge clk);
        start = 1'b1; dividend = 32'h41200000; divisor = 32'h40E00000;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (5) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        start = 1'b1; dividend = 32'h3F800000; divisor = 32'h00000000;
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks += 3;
        if (!done || lat !== 28) begin
            errors++; $display("FAIL busy_ignore_latency: got %0d done=%b expected 28", lat, done);
        end
        if (quotient !== e) begin
            errors++; $display("FAIL busy_ignore_q: got %h expected %h", quotient, e);
        end
        extra = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        if (extra !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_no_second_op: got %0d done pulses busy=%b expected 0 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] q;
        int lat, pulses;
        @(negedge clk);
        start = 1'b1; dividend = 32'h40A00000; divisor = 32'h40400000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL midreset_busy: got %b expected 0", busy);
        end
        if (done !== 1'b0) begin
            errors++; $display("FAIL midreset_done: got %b expected 0", done);
        end
        if (quotient !== 32'h0) begin
            errors++; $display("FAIL midreset_quotient: got %h expected 00000000", quotient);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", pulses);
        end
        run_op(32'h40A00000, 32'h40400000, q, lat);
        checks++;
        if (lat !== 28 || q !== ref_div(32'h40A00000, 32'h40400000)) begin
            errors++;
            $display("FAIL midreset_recover: got %h lat %0d expected %h lat 28", q, lat,
                     ref_div(32'h40A00000, 32'h40400000));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
